rn_credit_ctrl: RTL and testbench
=================================

Name: rn_credit_ctrl

Overview:
Credit-based dispatch controller between the decode/rename pipeline stage and the backend, which consists of the ROB and the issue queue.
- Tracks free ROB and issue-queue (IQ) entries from the rename push count, IQ issue count and ROB commit count.
- Generates the registered rn_stall_req that freezes decode.
- On flush, sequences a fixed drain window and then restores full credit.

Parameters:
CONFIG_P_ISSUE_WIDTH, 1, log2 of issue width IW; max push per cycle is IW.
CONFIG_P_COMMIT_WIDTH, 1, log2 of commit width CW; max ROB/IQ release per cycle is CW.
CONFIG_ROB_DEPTH, 16, ROB entries (>= IW).
CONFIG_IQ_DEPTH, 8, IQ entries (>= IW).
CONFIG_DRAIN_CYCLES, 2, cycles held in DRAIN after a flush (>= 1).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  pipeline flush request
rn_push_size  in  CONFIG_P_ISSUE_WIDTH+1  insns entering ROB+IQ this cycle
iq_issue_cnt  in  CONFIG_P_COMMIT_WIDTH+1  IQ entries freed this cycle
rob_commit_cnt  in  CONFIG_P_COMMIT_WIDTH+1  ROB entries freed this cycle
rn_stall_req  out  1  registered stall to decode/rename
rob_free  out  clog2(ROB_DEPTH+1)  free ROB credits
iq_free  out  clog2(IQ_DEPTH+1)  free IQ credits
ctrl_state  out  2  INIT=0, RUN=1, DRAIN=2
err_credit  out  1  sticky credit overflow/underflow flag

Behaviour:
Reset:
- Synchronous, active-high.
- After reset: ctrl_state=INIT, rn_stall_req=1, rob_free=ROB_DEPTH, iq_free=IQ_DEPTH, err_credit=0, drain counter=0.

FSM:
- INIT -> RUN unconditionally after one cycle. rn_stall_req is 0 from the RUN cycle onward unless the credit rule below stalls.
- RUN -> DRAIN on flush=1.
- DRAIN:
  - The counter loads CONFIG_DRAIN_CYCLES-1 on entry and decrements each cycle.
  - DRAIN -> RUN when the counter is 0 and flush=0.
  - flush=1 while in DRAIN reloads the counter.
- flush in INIT moves to DRAIN.

Credit update (RUN only):
- rob_nxt = rob_free - rn_push_size + rob_commit_cnt.
- iq_nxt = iq_free - rn_push_size + iq_issue_cnt.
- Compute at width+1 bits signed.
- Push and release in the same cycle net together.
- A result < 0 saturates to 0 and sets err_credit.
- A result > depth saturates to depth and sets err_credit.
- err_credit is cleared only by rst.
- A nonzero rn_push_size while rn_stall_req=1 is a protocol violation: the push is still counted and err_credit is set.

Flush:
- In the flush cycle, rob_free and iq_free load the full depth (all in-flight entries discarded).
- In INIT and DRAIN, all push/issue/commit inputs are ignored and credits hold at full depth.

Stall (registered, one-cycle latency):
- rn_stall_req <= (state_nxt != RUN) | (rob_nxt < IW) | (iq_nxt < IW).
- Using next-state credits guarantees that a group of up to IW always fits the cycle after stall=0.
- rn_stall_req is 1 throughout DRAIN and for the flush cycle's successor.
- rn_stall_req drops in the first RUN cycle after DRAIN.

Outputs:
- rob_free and iq_free are registered and update one cycle after their inputs.
- No combinational paths from inputs to outputs.

Test Plan:
(IW=2, CW=2, ROB=16, IQ=8, DRAIN=2)
1. Reset: rst high 2 cycles, then low -> cycle0 state=INIT, stall=1; cycle1 state=RUN, stall=0, rob_free=16, iq_free=8.
2. Fill IQ: push 2/cycle, no release -> iq_free 8,6,4,2,0; stall=1 registered with iq_free=0; rob_free=8; err_credit=0.
3. Recover from the full state of test 2: iq_issue_cnt=1 -> iq_free=1, stall stays 1; iq_issue_cnt=1 again -> iq_free=2, stall=0 next cycle.
4. Simultaneous push and release: iq_free=2, push 2 + iq_issue_cnt 2 -> iq_free stays 2, stall stays 0.
5. Flush: in RUN with rob_free=6, iq_free=2, assert flush 1 cycle with push=2 -> next cycle state=DRAIN, rob_free=16, iq_free=8, stall=1; inputs ignored 2 cycles; then RUN, stall=0. A second flush mid-DRAIN extends DRAIN by 2 cycles.
6. Errors:
   - push=2 while stall=1 -> err_credit=1 and stays 1 until rst.
   - Separately, rob_commit_cnt=2 at rob_free=16 -> rob_free=16 saturated, err_credit=1.

Source files
------------

// File: rtl/rn_credit_ctrl_if.sv
// Rename-to-backend dispatch credit interface: flush, push/issue/commit counts in; stall and credit status out.
// Latency: not applicable (wiring only); every status signal is driven from a register in the controller.
// Backpressure: the controller asserts rn_stall_req; rename must hold rn_push_size at 0 while it is high.
//   master: rename/backend side (drives flush and counts, observes status)
//   slave : rn_credit_ctrl (observes flush and counts, drives status)
interface rn_credit_ctrl_if #(
  parameter int CONFIG_P_ISSUE_WIDTH  = 1,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_ROB_DEPTH      = 16,
  parameter int CONFIG_IQ_DEPTH       = 8
);
  logic                                     flush;
  logic [CONFIG_P_ISSUE_WIDTH:0]            rn_push_size;
  logic [CONFIG_P_COMMIT_WIDTH:0]           iq_issue_cnt;
  logic [CONFIG_P_COMMIT_WIDTH:0]           rob_commit_cnt;
  logic                                     rn_stall_req;
  logic [$clog2(CONFIG_ROB_DEPTH+1)-1:0]    rob_free;
  logic [$clog2(CONFIG_IQ_DEPTH+1)-1:0]     iq_free;
  logic [1:0]                               ctrl_state;
  logic                                     err_credit;

  modport master (
    output flush, rn_push_size, iq_issue_cnt, rob_commit_cnt,
    input  rn_stall_req, rob_free, iq_free, ctrl_state, err_credit
  );

  modport slave (
    input  flush, rn_push_size, iq_issue_cnt, rob_commit_cnt,
    output rn_stall_req, rob_free, iq_free, ctrl_state, err_credit
  );
endinterface

// File: rtl/rn_credit_ctrl.sv
// Dispatch credit controller: tracks free ROB/IQ entries, sequences flush drain, raises stall to decode.
// Latency: all outputs registered; credits and stall reflect inputs one cycle later.
// Backpressure: rn_stall_req is set whenever the next cycle could not absorb a full issue group.
//   clk, rst (sync, active-high)
//   bus.slave: flush, rn_push_size, iq_issue_cnt, rob_commit_cnt in;
//              rn_stall_req, rob_free, iq_free, ctrl_state (INIT=0/RUN=1/DRAIN=2), err_credit out
module rn_credit_ctrl #(
  parameter int CONFIG_P_ISSUE_WIDTH  = 1,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_ROB_DEPTH      = 16,
  parameter int CONFIG_IQ_DEPTH       = 8,
  parameter int CONFIG_DRAIN_CYCLES   = 2
) (
  input  logic           clk,
  input  logic           rst,
  rn_credit_ctrl_if.slave bus
);
  localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int RW = $clog2(CONFIG_ROB_DEPTH + 1);
  localparam int QW = $clog2(CONFIG_IQ_DEPTH + 1);
  localparam int DW = (CONFIG_DRAIN_CYCLES > 1) ? $clog2(CONFIG_DRAIN_CYCLES) : 1;

  localparam logic [RW-1:0] ROB_FULL   = RW'(CONFIG_ROB_DEPTH);
  localparam logic [QW-1:0] IQ_FULL    = QW'(CONFIG_IQ_DEPTH);
  localparam logic [RW-1:0] ROB_MIN    = RW'(IW);
  localparam logic [QW-1:0] IQ_MIN     = QW'(IW);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(CONFIG_DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                         state_q, state_nxt;
  logic [DW-1:0]                  drain_q, drain_nxt;
  logic [RW-1:0]                  rob_q, rob_nxt;
  logic [QW-1:0]                  iq_q, iq_nxt;
  logic                           stall_q, stall_nxt;
  logic                           err_q, err_nxt;

  logic [CONFIG_P_ISSUE_WIDTH:0]  push_cnt;
  logic [CONFIG_P_COMMIT_WIDTH:0] issue_cnt;
  logic [CONFIG_P_COMMIT_WIDTH:0] commit_cnt;

  // One extra bit so a transient negative or above-depth result is visible before clamping.
  logic signed [RW:0]             rob_sum;
  logic signed [QW:0]             iq_sum;
  logic                           rob_under, rob_over, iq_under, iq_over;
  logic                           push_vld;

  assign push_cnt   = bus.rn_push_size;
  assign issue_cnt  = bus.iq_issue_cnt;
  assign commit_cnt = bus.rob_commit_cnt;
  assign push_vld   = (push_cnt != '0);

  always_comb begin
    rob_sum   = $signed({1'b0, rob_q}) - $signed((RW+1)'(push_cnt)) + $signed((RW+1)'(commit_cnt));
    iq_sum    = $signed({1'b0, iq_q})  - $signed((QW+1)'(push_cnt)) + $signed((QW+1)'(issue_cnt));
    rob_under = rob_sum[RW];
    iq_under  = iq_sum[QW];
    rob_over  = !rob_sum[RW] && (rob_sum > $signed({1'b0, ROB_FULL}));
    iq_over   = !iq_sum[QW]  && (iq_sum  > $signed({1'b0, IQ_FULL}));
  end

  always_comb begin
    state_nxt = state_q;
    drain_nxt = drain_q;
    rob_nxt   = rob_q;
    iq_nxt    = iq_q;
    err_nxt   = err_q;

    if (bus.flush) begin
      // Everything in flight is discarded: full credit immediately, then a fixed drain window.
      // Nothing is counted in the flush cycle, so it cannot raise err_credit either.
      state_nxt = ST_DRAIN;
      drain_nxt = DRAIN_LOAD;
      rob_nxt   = ROB_FULL;
      iq_nxt    = IQ_FULL;
    end else begin
      case (state_q)
        ST_RUN: begin
          rob_nxt = rob_under ? '0 : (rob_over ? ROB_FULL : rob_sum[RW-1:0]);
          iq_nxt  = iq_under  ? '0 : (iq_over  ? IQ_FULL  : iq_sum[QW-1:0]);
          // A push against a raised stall is still counted above, but flagged.
          if (rob_under || rob_over || iq_under || iq_over || (push_vld && stall_q)) begin
            err_nxt = 1'b1;
          end
        end
        ST_DRAIN: begin
          rob_nxt = ROB_FULL;
          iq_nxt  = IQ_FULL;
          if (drain_q == '0) begin
            state_nxt = ST_RUN;
          end else begin
            drain_nxt = drain_q - DW'(1);
          end
        end
        default: begin
          state_nxt = ST_RUN;
          rob_nxt   = ROB_FULL;
          iq_nxt    = IQ_FULL;
        end
      endcase
    end

    // Judged on next-cycle credit so that any group of up to IW fits once stall is low.
    stall_nxt = (state_nxt != ST_RUN) || (rob_nxt < ROB_MIN) || (iq_nxt < IQ_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      drain_q <= '0;
      rob_q   <= ROB_FULL;
      iq_q    <= IQ_FULL;
      stall_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      drain_q <= drain_nxt;
      rob_q   <= rob_nxt;
      iq_q    <= iq_nxt;
      stall_q <= stall_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.rn_stall_req = stall_q;
  assign bus.rob_free     = rob_q;
  assign bus.iq_free      = iq_q;
  assign bus.ctrl_state   = state_q;
  assign bus.err_credit   = err_q;
endmodule

// File: tb/tb_rn_credit_ctrl.sv
// Testbench for rn_credit_ctrl: directed walkthrough plus constrained-random traffic.
// Expected outputs are predicted per cycle by an arithmetic model and queued; a negedge monitor compares.
module tb_rn_credit_ctrl;
  localparam int P_IW  = 1;
  localparam int P_CW  = 1;
  localparam int ROB   = 16;
  localparam int IQ    = 8;
  localparam int DRAIN = 2;
  localparam int IW    = 1 << P_IW;
  localparam int CW    = 1 << P_CW;

  localparam int S_INIT  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rn_credit_ctrl_if #(
    .CONFIG_P_ISSUE_WIDTH(P_IW), .CONFIG_P_COMMIT_WIDTH(P_CW),
    .CONFIG_ROB_DEPTH(ROB), .CONFIG_IQ_DEPTH(IQ)
  ) bus ();

  rn_credit_ctrl #(
    .CONFIG_P_ISSUE_WIDTH(P_IW), .CONFIG_P_COMMIT_WIDTH(P_CW),
    .CONFIG_ROB_DEPTH(ROB), .CONFIG_IQ_DEPTH(IQ), .CONFIG_DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int state;
    bit stall;
    int rob;
    int iq;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  // Reference model: mode, free counts, sticky error, and DRAIN cycles still to run.
  int m_state, m_rob, m_iq, m_left;
  bit m_stall, m_err;

  function automatic void check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL queue_underflow: got 0 entries expected at least 1 at t=%0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("ctrl_state",   32'(bus.ctrl_state),   mon_e.state);
        check("rn_stall_req", 32'(bus.rn_stall_req), int'(mon_e.stall));
        check("rob_free",     32'(bus.rob_free),     mon_e.rob);
        check("iq_free",      32'(bus.iq_free),      mon_e.iq);
        check("err_credit",   32'(bus.err_credit),   int'(mon_e.err));
      end
    end
  end

  task automatic model_step(input bit fl, input int push, input int iss, input int com);
    int r, q;
    if (fl) begin
      m_state = S_DRAIN;
      m_left  = DRAIN;
      m_rob   = ROB;
      m_iq    = IQ;
    end else if (m_state == S_INIT) begin
      m_state = S_RUN;
    end else if (m_state == S_DRAIN) begin
      m_rob = ROB;
      m_iq  = IQ;
      if (m_left > 1) m_left = m_left - 1;
      else            m_state = S_RUN;
    end else begin
      if (push != 0 && m_stall) m_err = 1'b1;
      r = m_rob - push + com;
      q = m_iq - push + iss;
      if (r < 0 || r > ROB || q < 0 || q > IQ) m_err = 1'b1;
      m_rob = clamp(r, ROB);
      m_iq  = clamp(q, IQ);
    end
    m_stall = (m_state != S_RUN) || (m_rob < IW) || (m_iq < IW);
  endtask

  task automatic drive(input bit fl, input int push, input int iss, input int com);
    bus.flush          = fl;
    bus.rn_push_size   = push[P_IW:0];
    bus.iq_issue_cnt   = iss[P_CW:0];
    bus.rob_commit_cnt = com[P_CW:0];
  endtask

  task automatic cycle(input bit fl, input int push, input int iss, input int com);
    drive(fl, push, iss, com);
    model_step(fl, push, iss, com);
    exp_q.push_back('{state: m_state, stall: m_stall, rob: m_rob, iq: m_iq, err: m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    rst    = 1'b1;
    drive(1'b0, 0, 0, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_state = S_INIT;
    m_stall = 1'b1;
    m_rob   = ROB;
    m_iq    = IQ;
    m_err   = 1'b0;
    m_left  = 0;
    exp_q.push_back('{state: m_state, stall: m_stall, rob: m_rob, iq: m_iq, err: m_err});
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 0, 0, 0);

    // Reset, INIT for one cycle, then RUN with full credit.
    do_reset();
    cycle(0, 0, 0, 0);

    // Fill the IQ two at a time until it stalls.
    repeat (4) cycle(0, 2, 0, 0);
    // Release one at a time: still stalled at 1, clear at 2.
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    // Push and issue in the same cycle net to zero.
    cycle(0, 2, 2, 0);

    // Flush with a push present; DRAIN ignores inputs, then back to RUN.
    cycle(1, 2, 0, 0);
    cycle(0, 0, 2, 2);
    cycle(0, 0, 2, 2);
    cycle(0, 0, 0, 0);

    // Second flush in the middle of DRAIN extends the window.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Protocol violation: push while stalled; error is sticky, even across a flush.
    repeat (4) cycle(0, 2, 0, 0);
    cycle(0, 2, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Over-commit against a full ROB saturates and flags.
    do_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 2);
    cycle(0, 0, 0, 0);

    // Over-issue against a full IQ saturates and flags.
    do_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 2, 0);
    cycle(0, 0, 0, 0);

    // Constrained-random traffic, with occasional flushes, violations and over-releases.
    for (int b = 0; b < 4; b++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        bit fl;
        int push, iss, com;
        fl   = ($urandom_range(0, 39) == 0);
        push = m_stall ? 0 : int'($urandom_range(0, IW));
        if (m_state == S_RUN && !fl && m_stall && $urandom_range(0, 49) == 0)
          push = int'($urandom_range(1, IW));
        if ($urandom_range(0, 63) == 0) begin
          iss = int'($urandom_range(0, CW));
          com = int'($urandom_range(0, CW));
        end else begin
          iss = int'($urandom_range(0, imin(CW, IQ - m_iq)));
          com = int'($urandom_range(0, imin(CW, ROB - m_rob)));
        end
        cycle(fl, push, iss, com);
      end
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
